// File: rtl/dec_n_scan.sv
// Registered N-to-2^N one-hot decoder with load, enable and auto-scan (DIV-cycle dwell).
// Optional macro DEC_PULSE_EN: y pulses once per load (direct) or once per dwell (scan).
module dec_n_scan #(
  parameter int N   = 2,
  parameter int DIV = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic                ld,
  input  logic [N-1:0]        a,
  output logic [(1<<N)-1:0]   y,
  output logic [N-1:0]        idx,
  output logic                wrap
);

  localparam int W  = 1 << N;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DIV - 1);

  logic [N-1:0]  idx_q,   idx_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          mode_q,  mode_d;
  logic [W-1:0]  y_q,     y_d;
  logic          wrap_q,  wrap_d;

  // NOTE: every variable gets a default before any branch so no path leaves one unassigned (no latches).
  always_comb begin
    idx_d   = idx_q;
    dwell_d = dwell_q;
    mode_d  = mode;
    wrap_d  = 1'b0;
    y_d     = '0;

    if (en) begin
      if (ld) begin
        idx_d   = a;
        dwell_d = '0;
      end else if (mode != mode_q) begin
        dwell_d = '0;
      end else if (mode && dwell_q == DWELL_LAST) begin
        dwell_d = '0;
        idx_d   = idx_q + N'(1);
        wrap_d  = (idx_q == '1);
      end else if (mode) begin
        dwell_d = dwell_q + DW'(1);
      end else begin
        dwell_d = '0;
      end

`ifdef DEC_PULSE_EN
      if (mode) begin
        if (dwell_d == '0) y_d = W'(1) << idx_d;
      end else if (ld) begin
        y_d = W'(1) << idx_d;
      end
`else
      y_d = W'(1) << idx_d;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      dwell_q <= '0;
      mode_q  <= 1'b0;
      y_q     <= '0;
      wrap_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
      y_q     <= y_d;
      wrap_q  <= wrap_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_dec_n_scan.sv
// Self-checking bench for dec_n_scan (N=2, DIV=4) against a sweep-position reference model.
module tb_dec_n_scan;

  localparam int N   = 2;
  localparam int DIV = 4;
  localparam int W   = 1 << N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0, mode = 1'b0, ld = 1'b0;
  logic [N-1:0] a = '0;
  logic [W-1:0] y;
  logic [N-1:0] idx;
  logic         wrap;

  int checks = 0;
  int errors = 0;

  // Model: position within the whole sweep, pos = idx*DIV + dwell.
  int           m_pos = 0;
  logic         m_mode_q = 1'b0;
  logic [W-1:0] m_y = '0;
  logic [N-1:0] m_idx = '0;
  logic         m_wrap = 1'b0;

  dec_n_scan #(.N(N), .DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .ld(ld), .a(a),
    .y(y), .idx(idx), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pos = 0; m_mode_q = 1'b0; m_y = '0; m_idx = '0; m_wrap = 1'b0;
  endtask

  task automatic model_edge();
    if (!en) begin
      m_y = '0;
      m_wrap = 1'b0;
    end else begin
      m_wrap = 1'b0;
      if (ld)                  m_pos = int'(a) * DIV;
      else if (mode != m_mode_q) m_pos = (m_pos / DIV) * DIV;
      else if (mode) begin
        m_pos = (m_pos + 1) % (DIV * W);
        m_wrap = (m_pos == 0);
      end else                 m_pos = (m_pos / DIV) * DIV;
      m_idx = N'(m_pos / DIV);
`ifdef DEC_PULSE_EN
      if (mode) m_y = (m_pos % DIV == 0) ? (W'(1) << m_idx) : '0;
      else      m_y = ld ? (W'(1) << m_idx) : '0;
`else
      m_y = W'(1) << m_idx;
`endif
    end
    m_mode_q = mode;
  endtask

  // Apply inputs, take one edge, advance the model, and return 1 time unit after the edge.
  task automatic tick(input logic t_en, input logic t_ld, input logic [N-1:0] t_a, input logic t_mode);
    en = t_en; ld = t_ld; a = t_a; mode = t_mode;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    en = 1'b1; ld = 1'b1; a = 2'b11; mode = 1'b1;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({y, idx, wrap} !== 7'b0) begin
      errors++;
      $display("FAIL reset_immediate got y=%b idx=%b wrap=%b want 0000 00 0", y, idx, wrap);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({y, idx, wrap} !== 7'b0) begin
      errors++;
      $display("FAIL reset_held got y=%b idx=%b wrap=%b want 0000 00 0", y, idx, wrap);
    end
    en = 1'b0; ld = 1'b0; mode = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 2'b00, 1'b0);
      checks++;
      if ({y, idx, wrap} !== 7'b0) begin
        errors++;
        $display("FAIL reset_release c%0d got y=%b idx=%b wrap=%b want 0000 00 0", i, y, idx, wrap);
      end
    end
  endtask

  task automatic test_direct();
    tick(1'b1, 1'b1, 2'b10, 1'b0);
    checks++;
    if (y !== 4'b0100 || idx !== 2'b10) begin
      errors++;
      $display("FAIL direct_load got y=%b idx=%b want 0100 10", y, idx);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 2'(i), 1'b0);
      checks++;
      if ({y, idx, wrap} !== {m_y, m_idx, m_wrap}) begin
        errors++;
        $display("FAIL direct_hold got %b/%b/%b want %b/%b/%b", y, idx, wrap, m_y, m_idx, m_wrap);
      end
    end
`ifndef DEC_PULSE_EN
    checks++;
    if (y !== 4'b0100 || idx !== 2'b10) begin
      errors++;
      $display("FAIL direct_hold_const got y=%b idx=%b want 0100 10", y, idx);
    end
`endif
    tick(1'b0, 1'b1, 2'b01, 1'b0);
    checks++;
    if (y !== 4'b0000 || idx !== 2'b10 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL direct_disable got y=%b idx=%b wrap=%b want 0000 10 0", y, idx, wrap);
    end
  endtask

  task automatic test_scan_sweep();
    int wraps = 0;
    tick(1'b1, 1'b1, 2'b00, 1'b1);
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) tick(1'b1, 1'b0, 2'b00, 1'b1);
      if (k > 0 && wrap === 1'b1) wraps++;
      checks++;
      if ({y, idx, wrap} !== {m_y, m_idx, m_wrap}) begin
        errors++;
        $display("FAIL scan_model k=%0d got %b/%b/%b want %b/%b/%b", k, y, idx, wrap, m_y, m_idx, m_wrap);
      end
`ifndef DEC_PULSE_EN
      checks++;
      if (y !== (4'b0001 << ((k % 16) / 4)) || wrap !== (k == 16)) begin
        errors++;
        $display("FAIL scan_sweep k=%0d got y=%b wrap=%b want y=%b wrap=%0d",
                 k, y, wrap, 4'b0001 << ((k % 16) / 4), (k == 16));
      end
`endif
    end
    checks++;
    if (wraps !== 1) begin
      errors++;
      $display("FAIL scan_wrap_count got %0d want 1", wraps);
    end
  endtask

  task automatic test_ld_scan_pause();
    logic [N-1:0] held;
    tick(1'b1, 1'b0, 2'b00, 1'b1);
    tick(1'b1, 1'b1, 2'b11, 1'b1);
    checks++;
    if (idx !== 2'b11 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL ld_scan got idx=%b wrap=%b want 11 0", idx, wrap);
    end
    for (int k = 1; k <= 4; k++) begin
      tick(1'b1, 1'b0, 2'b00, 1'b1);
      checks++;
      if ({y, idx, wrap} !== {m_y, m_idx, m_wrap}) begin
        errors++;
        $display("FAIL ld_scan_dwell k=%0d got %b/%b/%b want %b/%b/%b", k, y, idx, wrap, m_y, m_idx, m_wrap);
      end
    end
`ifndef DEC_PULSE_EN
    checks++;
    if (y !== 4'b0001 || wrap !== 1'b1) begin
      errors++;
      $display("FAIL ld_scan_wrap got y=%b wrap=%b want 0001 1", y, wrap);
    end
`endif
    tick(1'b1, 1'b0, 2'b00, 1'b1);
    held = idx;
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0, 2'b00, 1'b1);
      checks++;
      if (y !== 4'b0000 || idx !== held) begin
        errors++;
        $display("FAIL pause k=%0d got y=%b idx=%b want 0000 %b", k, y, idx, held);
      end
    end
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, 1'b0, 2'b00, 1'b1);
      checks++;
      if ({y, idx, wrap} !== {m_y, m_idx, m_wrap}) begin
        errors++;
        $display("FAIL resume k=%0d got %b/%b/%b want %b/%b/%b", k, y, idx, wrap, m_y, m_idx, m_wrap);
      end
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    tick(1'b1, 1'b1, 2'b10, 1'b1);
    while (m_pos % DIV != 1 && guard < 50) begin
      tick(1'b1, 1'b0, 2'b00, 1'b1);
      guard++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({y, idx, wrap} !== 7'b0) begin
      errors++;
      $display("FAIL async_reset got y=%b idx=%b wrap=%b want 0000 00 0", y, idx, wrap);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick(1'b1, 1'b0, 2'b00, 1'b1);
      checks++;
      if ({y, idx, wrap} !== {m_y, m_idx, m_wrap}) begin
        errors++;
        $display("FAIL after_reset k=%0d got %b/%b/%b want %b/%b/%b", k, y, idx, wrap, m_y, m_idx, m_wrap);
      end
    end
    checks++;
    if (idx !== 2'b01) begin
      errors++;
      $display("FAIL after_reset_idx got %b want 01", idx);
    end
  endtask

  task automatic test_random();
    logic r_en, r_ld, r_mode;
    r_mode = mode;
    for (int k = 0; k < 400; k++) begin
      r_en = ($urandom_range(0, 9) != 0);
      r_ld = ($urandom_range(0, 11) == 0);
      if (r_en && $urandom_range(0, 19) == 0) r_mode = ~r_mode;
      tick(r_en, r_ld, N'($urandom), r_mode);
      checks++;
      if ({y, idx, wrap} !== {m_y, m_idx, m_wrap}) begin
        errors++;
        $display("FAIL random k=%0d got %b/%b/%b want %b/%b/%b", k, y, idx, wrap, m_y, m_idx, m_wrap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan_sweep();
    test_ld_scan_pause();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dec_n_scan.md
# dec_n_scan

Parametrised N-to-2^N decoder with enable, a registered one-hot output, and an auto-scan mode. In direct mode it holds the one-hot decode of a loaded index. In scan mode it steps through all 2^N outputs, dwelling DIV cycles on each. It replaces the combinational 2-to-4 enable decoder wherever a registered select or multiplexed-drive sequence is needed, such as display digit strobing or bank selects.

## Interface
- N, default 2: index width; output width is 2^N (N >= 1).
- DIV, default 4: dwell cycles per output in scan mode (DIV >= 1).
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- en  in  1  enable; 0 forces y to zero and freezes the index and dwell counter.
- mode  in  1  0 = direct decode, 1 = auto-scan.
- ld  in  1  load strobe; captures a into the index.
- a  in  N  index to load.
- y  out  2^N  registered one-hot output.
- idx  out  N  current index register.
- wrap  out  1  one-cycle pulse when the scan index wraps from 2^N-1 to 0.

## Operation
- State:
  - idx register, N bits.
  - dwell counter, width clog2(DIV), minimum 1 bit.
  - mode_q, the previous value of mode.
  - registered y and wrap.
- Reset (rst_n=0): idx=0, dwell=0, y=0, wrap=0, mode_q=0.
- Priority at each edge, highest first:
  1. en=0: idx and dwell hold, y<=0, wrap<=0. ld is ignored.
  2. ld=1: idx<=a, dwell<=0, wrap<=0. Applies in both modes.
  3. mode!=mode_q: dwell<=0, idx holds.
  4. Scan step, when mode=1 and dwell==DIV-1: dwell<=0 and idx<=idx+1 modulo 2^N. wrap<=1 only if the old idx was 2^N-1.
  5. Otherwise in scan mode: dwell<=dwell+1, wrap<=0.
  6. Direct mode with no ld: idx holds, dwell holds at 0, wrap<=0.
- Output rule: y<=onehot(idx_next) when en=1, else 0. y therefore always matches the idx register value from the same edge.
- Exactly one bit of y is set whenever en=1. No bit is set when en=0.
- a is used unmodified. Every N-bit value is a legal index, so no out-of-range case exists.
- DIV=1: scan advances idx every enabled cycle.

## Timing
- Latency from ld to y/idx: 1 clock. The values are visible after the edge that samples ld=1.
- Scan period: DIV x 2^N enabled cycles per full sweep. wrap is high for exactly one cycle per sweep, on the edge where idx becomes 0.
- Disabling en pauses the dwell count without losing progress. Re-enabling resumes from the frozen dwell value, and y returns on the first enabled edge.
- Simultaneous ld and scan step: ld wins, and wrap stays 0 even if a=0.
- Mode change restarts dwell on the switching edge. The first scan output after entering scan mode is the held idx, shown for a full DIV cycles.
- Asynchronous reset asserted mid-operation clears all outputs immediately, without waiting for clk. Release is synchronous to the next rising edge.

## Configuration
- Macro: DEC_PULSE_EN.
- Undefined (default): y holds its one-hot value for as long as the index is valid, as described above.
- Defined, direct mode: y shows onehot(a) for exactly the one cycle after an edge with ld=1, then returns to 0 while idx holds.
- Defined, scan mode: y is asserted only in the cycle where dwell==0 and is 0 for the remaining DIV-1 cycles of each dwell.
- wrap and idx behave the same with or without the macro.

## Test plan
All scenarios use N=2, DIV=4.
- Reset: rst_n=0 with any inputs -> y=0000, idx=00, wrap=0 immediately. All stay at reset values after release until the first enabled event.
- Direct decode: en=1, mode=0, ld=1, a=10 for one cycle -> next edge y=0100, idx=10, and both hold with ld=0. Then en=0 -> y=0000 next edge, idx stays 10, and ld with a=01 is ignored.
- Scan sweep: en=1, mode=1 from idx=00 -> y reads 0001, 0010, 0100, 1000 for 4 cycles each, then 0001 again. wrap=1 only on the cycle idx returns to 00 (cycle 16 of the sweep).
- ld during scan and enable pause:
  - ld=1, a=11 mid-dwell -> idx=11, y=1000 next edge, held for 4 cycles, then wrap=1 with y=0001.
  - en=0 for 3 cycles mid-dwell, then back to 1 -> remaining dwell cycles preserved.
- Asynchronous reset mid-scan: drop rst_n between clock edges while y=0100 -> y=0000, idx=00, wrap=0 before the next edge. Scan restarts from 0001 after release.
- DEC_PULSE_EN defined:
  - Direct ld with a=01 -> y=0010 for one cycle, then 0000 while idx=01.
  - Scan -> each output bit pulses once per 4 cycles.
